// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI mode-0 slave: default word width,
// synchronizer depth, bus mode and FSM state encoding.
package spi_slave_pkg;

    localparam int   SPI_DEFAULT_N   = 32;
    localparam int   SPI_SYNC_STAGES = 2;
    localparam logic SPI_CPOL        = 1'b0;
    localparam logic SPI_CPHA        = 1'b0;

    typedef enum logic {
        SPI_S_IDLE  = 1'b0,
        SPI_S_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by one extra
// register so that single-cycle rise/fall pulses can be derived from it.
module spi_slave_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave on the system clock: oversampled pins, N-bit rx
// deserializer and a tx serializer fed from a one-entry transmit buffer.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int N = SPI_DEFAULT_N
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         sclk,
    input  logic         cs_b,
    input  logic         sdi,
    output logic         sdo,
    output logic         sdo_oe,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         tx_underrun,
    output logic         frame_err
);

    localparam int CW = $clog2(N);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic sample_edge, shift_edge;
    logic sdi_s;
    logic load_tx;

    logic [SPI_SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    spi_state_e                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       word_done_q, word_done_d;
    logic [N-1:0]               rx_shift_q, rx_shift_d;
    logic [N-1:0]               rx_data_q, rx_data_d;
    logic                       rx_valid_q, rx_valid_d;
    logic [N-1:0]               tx_shift_q, tx_shift_d;
    logic [N-1:0]               tx_buf_q, tx_buf_d;
    logic                       tx_full_q, tx_full_d;
    logic                       sdo_oe_q, sdo_oe_d;
    logic                       tx_underrun_q, tx_underrun_d;
    logic                       frame_err_q, frame_err_d;

    spi_slave_sync_edge #(
        .STAGES    (SPI_SYNC_STAGES),
        .RESET_VAL (SPI_CPOL)
    ) u_sclk_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .async_in (sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_slave_sync_edge #(
        .STAGES    (SPI_SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .async_in (cs_b),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Mode 0 samples on the leading (rising) edge and shifts on the trailing one.
    assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
    assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;
    assign sdi_s       = sdi_sync_q[SPI_SYNC_STAGES-1];

    always_comb begin
        sdi_sync_d    = {sdi_sync_q[SPI_SYNC_STAGES-2:0], sdi};
        state_d       = state_q;
        cnt_d         = cnt_q;
        word_done_d   = word_done_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_shift_d    = tx_shift_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        sdo_oe_d      = sdo_oe_q;
        tx_underrun_d = 1'b0;
        frame_err_d   = 1'b0;
        load_tx       = 1'b0;

        if (cs_rise) begin
            state_d     = SPI_S_IDLE;
            frame_err_d = (cnt_q != '0);
            cnt_d       = '0;
            word_done_d = 1'b0;
            rx_shift_d  = '0;
            tx_shift_d  = '0;
            sdo_oe_d    = 1'b0;
        end else if (cs_fall && state_q == SPI_S_IDLE) begin
            state_d     = SPI_S_SHIFT;
            cnt_d       = '0;
            word_done_d = 1'b0;
            rx_shift_d  = '0;
            sdo_oe_d    = 1'b1;
            load_tx     = 1'b1;
        end else if (state_q == SPI_S_SHIFT) begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[N-2:0], sdi_s};
                if (cnt_q == CW'(N - 1)) begin
                    rx_data_d   = rx_shift_d;
                    rx_valid_d  = 1'b1;
                    cnt_d       = '0;
                    word_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (shift_edge) begin
                if (word_done_q) begin
                    load_tx     = 1'b1;
                    word_done_d = 1'b0;
                end else begin
                    tx_shift_d = {tx_shift_q[N-2:0], 1'b0};
                end
            end
        end

        // A consume sees the old buffer; a same-cycle write then refills it.
        if (load_tx) begin
            tx_shift_d    = tx_full_q ? tx_buf_q : '0;
            tx_underrun_d = ~tx_full_q;
            tx_full_d     = 1'b0;
        end
        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sdi_sync_q    <= '0;
            state_q       <= SPI_S_IDLE;
            cnt_q         <= '0;
            word_done_q   <= 1'b0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            sdo_oe_q      <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sdi_sync_q    <= sdi_sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            word_done_q   <= word_done_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_shift_q    <= tx_shift_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            sdo_oe_q      <= sdo_oe_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign sdo         = tx_shift_q[N-1];
    assign sdo_oe      = sdo_oe_q;
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives a 32-bit
// and an 8-bit instance and checks both directions of every transfer.
module tb_spi_slave;

    localparam int H32 = 20;
    localparam int H8  = 4;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        sclk, cs_b, sdi, sdo, sdo_oe;
    logic [31:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, tx_underrun, frame_err;

    logic        sclk8, cs_b8, sdi8, sdo8, sdo_oe8;
    logic [7:0]  tx_data8, rx_data8;
    logic        tx_valid8, tx_ready8, rx_valid8, tx_underrun8, frame_err8;

    int checks = 0;
    int errors = 0;

    int          rx_cnt = 0, ur_cnt = 0, fe_cnt = 0, rx8_cnt = 0;
    logic [31:0] rx_last = '0, rx_prev = '0;
    logic [7:0]  rx8_last = '0;

    int          rx_base, ur_base, fe_base, rx8_base;
    logic [63:0] miso, miso2;

    always #5 sys_clk = ~sys_clk;

    spi_slave #(.N(32)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_b        (cs_b),
        .sdi         (sdi),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err)
    );

    spi_slave #(.N(8)) dut8 (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .sclk        (sclk8),
        .cs_b        (cs_b8),
        .sdi         (sdi8),
        .sdo         (sdo8),
        .sdo_oe      (sdo_oe8),
        .tx_data     (tx_data8),
        .tx_valid    (tx_valid8),
        .tx_ready    (tx_ready8),
        .rx_data     (rx_data8),
        .rx_valid    (rx_valid8),
        .tx_underrun (tx_underrun8),
        .frame_err   (frame_err8)
    );

    // Pulse monitor, sampled on the falling system clock edge.
    always @(negedge sys_clk) begin
        if (rx_valid) begin
            rx_prev <= rx_last;
            rx_last <= rx_data;
            rx_cnt  <= rx_cnt + 1;
        end
        if (tx_underrun) ur_cnt <= ur_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        if (rx_valid8) begin
            rx8_last <= rx_data8;
            rx8_cnt  <= rx8_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Mode-0 master: shift nbits of mosi (LSB-aligned, MSB first), capture sdo at each rise.
    task automatic applyStimulus(input bit sel, input int half, input int nbits,
                                 input logic [63:0] mosi, output logic [63:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (sel) sdi8 = mosi[i]; else sdi = mosi[i];
            repeat (half) @(negedge sys_clk);
            rx = {rx[62:0], (sel ? sdo8 : sdo)};
            if (sel) sclk8 = 1'b1; else sclk = 1'b1;
            repeat (half) @(negedge sys_clk);
            if (sel) sclk8 = 1'b0; else sclk = 1'b0;
        end
    endtask

    task automatic write_tx(input logic [31:0] d);
        @(negedge sys_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    task automatic write_tx8(input logic [7:0] d);
        @(negedge sys_clk);
        tx_data8  = d;
        tx_valid8 = 1'b1;
        @(negedge sys_clk);
        tx_valid8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sclk = 1'b0; cs_b = 1'b1; sdi = 1'b0; tx_data = '0; tx_valid = 1'b0;
        sclk8 = 1'b0; cs_b8 = 1'b1; sdi8 = 1'b0; tx_data8 = '0; tx_valid8 = 1'b0;
        repeat (4) @(negedge sys_clk);
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        $display("[TB] reset values");
        checkOutput("rst_sdo",         64'(sdo),         64'd0);
        checkOutput("rst_sdo_oe",      64'(sdo_oe),      64'd0);
        checkOutput("rst_rx_data",     64'(rx_data),     64'd0);
        checkOutput("rst_rx_valid",    64'(rx_valid),    64'd0);
        checkOutput("rst_tx_ready",    64'(tx_ready),    64'd1);
        checkOutput("rst_tx_underrun", 64'(tx_underrun), 64'd0);
        checkOutput("rst_frame_err",   64'(frame_err),   64'd0);
        checkOutput("rst8_tx_ready",   64'(tx_ready8),   64'd1);

        $display("[TB] receive with preloaded transmit");
        write_tx(32'h8877_6655);
        checkOutput("t1_tx_ready_full", 64'(tx_ready), 64'd0);
        rx_base = rx_cnt; ur_base = ur_cnt; fe_base = fe_cnt;
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        checkOutput("t1_tx_ready_after_cs", 64'(tx_ready), 64'd1);
        checkOutput("t1_sdo_oe",            64'(sdo_oe),   64'd1);
        checkOutput("t1_first_sdo",         64'(sdo),      64'd1);
        checkOutput("t1_no_underrun",       64'(ur_cnt - ur_base), 64'd0);
        applyStimulus(1'b0, H32, 32, 64'h4433_2211, miso);
        repeat (H32) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (8) @(negedge sys_clk);
        checkOutput("t1_miso",      miso,                  64'h8877_6655);
        checkOutput("t1_rx_count",  64'(rx_cnt - rx_base), 64'd1);
        checkOutput("t1_rx_data",   64'(rx_last),          64'h4433_2211);
        checkOutput("t1_no_ferr",   64'(fe_cnt - fe_base), 64'd0);
        checkOutput("t1_sdo_oe_end", 64'(sdo_oe),          64'd0);

        $display("[TB] back-to-back words");
        write_tx(32'hCAFE_F00D);
        rx_base = rx_cnt; ur_base = ur_cnt; fe_base = fe_cnt;
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        checkOutput("t2_tx_ready_after_cs", 64'(tx_ready), 64'd1);
        write_tx(32'hDEAD_BEEF);
        checkOutput("t2_tx_ready_refill", 64'(tx_ready), 64'd0);
        applyStimulus(1'b0, H32, 32, 64'h0123_4567, miso);
        applyStimulus(1'b0, H32, 32, 64'h89AB_CDEF, miso2);
        checkOutput("t2_rx_count",    64'(rx_cnt - rx_base), 64'd2);
        checkOutput("t2_no_underrun", 64'(ur_cnt - ur_base), 64'd0);
        repeat (H32) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (8) @(negedge sys_clk);
        checkOutput("t2_rx_word1", 64'(rx_prev), 64'h0123_4567);
        checkOutput("t2_rx_word2", 64'(rx_last), 64'h89AB_CDEF);
        checkOutput("t2_miso1",    miso,         64'hCAFE_F00D);
        checkOutput("t2_miso2",    miso2,        64'hDEAD_BEEF);
        checkOutput("t2_no_ferr",  64'(fe_cnt - fe_base), 64'd0);

        $display("[TB] empty buffer");
        rx_base = rx_cnt; ur_base = ur_cnt;
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        checkOutput("t3_underrun", 64'(ur_cnt - ur_base), 64'd1);
        checkOutput("t3_sdo_oe",   64'(sdo_oe),           64'd1);
        applyStimulus(1'b0, H32, 32, 64'h5A5A_C3C3, miso);
        repeat (H32) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (8) @(negedge sys_clk);
        checkOutput("t3_miso_zero", miso,                  64'd0);
        checkOutput("t3_rx_count",  64'(rx_cnt - rx_base), 64'd1);
        checkOutput("t3_rx_data",   64'(rx_last),          64'h5A5A_C3C3);

        $display("[TB] abort after 13 bits");
        write_tx(32'hF0F0_F0F0);
        rx_base = rx_cnt; fe_base = fe_cnt;
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        write_tx(32'h1357_9BDF);
        applyStimulus(1'b0, H32, 13, 64'h1FFF, miso);
        checkOutput("t4_partial_miso", miso, 64'h1E1E);
        repeat (H32) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (6) @(negedge sys_clk);
        checkOutput("t4_frame_err",   64'(fe_cnt - fe_base), 64'd1);
        checkOutput("t4_no_rx_valid", 64'(rx_cnt - rx_base), 64'd0);
        checkOutput("t4_sdo_oe",      64'(sdo_oe),           64'd0);
        checkOutput("t4_sdo",         64'(sdo),              64'd0);
        checkOutput("t4_rx_held",     64'(rx_data),          64'h5A5A_C3C3);
        checkOutput("t4_buffer_kept", 64'(tx_ready),         64'd0);
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        applyStimulus(1'b0, H32, 32, 64'h0F1E_2D3C, miso);
        repeat (H32) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (8) @(negedge sys_clk);
        checkOutput("t4_next_miso",    miso,                  64'h1357_9BDF);
        checkOutput("t4_next_rx_cnt",  64'(rx_cnt - rx_base), 64'd1);
        checkOutput("t4_next_rx_data", 64'(rx_last),          64'h0F1E_2D3C);
        checkOutput("t4_next_no_ferr", 64'(fe_cnt - fe_base), 64'd1);

        $display("[TB] reset mid-frame");
        write_tx(32'h1111_1111);
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        applyStimulus(1'b0, H32, 10, 64'h2AA, miso);
        rst = 1'b1;
        #1;
        checkOutput("t5_sdo",      64'(sdo),      64'd0);
        checkOutput("t5_sdo_oe",   64'(sdo_oe),   64'd0);
        checkOutput("t5_rx_data",  64'(rx_data),  64'd0);
        checkOutput("t5_rx_valid", 64'(rx_valid), 64'd0);
        checkOutput("t5_tx_ready", 64'(tx_ready), 64'd1);
        repeat (2) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        write_tx(32'h2468_ACE0);
        rx_base = rx_cnt; ur_base = ur_cnt; fe_base = fe_cnt;
        cs_b = 1'b0;
        repeat (6) @(negedge sys_clk);
        checkOutput("t5_no_underrun", 64'(ur_cnt - ur_base), 64'd0);
        applyStimulus(1'b0, H32, 32, 64'h7E7E_1234, miso);
        repeat (H32) @(negedge sys_clk);
        cs_b = 1'b1;
        repeat (8) @(negedge sys_clk);
        checkOutput("t5_miso",     miso,                  64'h2468_ACE0);
        checkOutput("t5_rx_count", 64'(rx_cnt - rx_base), 64'd1);
        checkOutput("t5_rx_data",  64'(rx_last),          64'h7E7E_1234);
        checkOutput("t5_no_ferr",  64'(fe_cnt - fe_base), 64'd0);

        $display("[TB] N=8 at sclk = sys_clk/8");
        write_tx8(8'h3C);
        rx8_base = rx8_cnt;
        cs_b8 = 1'b0;
        repeat (6) @(negedge sys_clk);
        checkOutput("t6_sdo_oe8", 64'(sdo_oe8), 64'd1);
        applyStimulus(1'b1, H8, 8, 64'hA5, miso);
        repeat (H8) @(negedge sys_clk);
        cs_b8 = 1'b1;
        repeat (6) @(negedge sys_clk);
        checkOutput("t6_miso_3c",   miso,                    64'h3C);
        checkOutput("t6_rx_a5",     64'(rx8_last),           64'hA5);
        checkOutput("t6_rx8_count", 64'(rx8_cnt - rx8_base), 64'd1);
        write_tx8(8'hA5);
        cs_b8 = 1'b0;
        repeat (6) @(negedge sys_clk);
        applyStimulus(1'b1, H8, 8, 64'h3C, miso);
        repeat (H8) @(negedge sys_clk);
        cs_b8 = 1'b1;
        repeat (6) @(negedge sys_clk);
        checkOutput("t6_miso_a5",    miso,                    64'hA5);
        checkOutput("t6_rx_3c",      64'(rx8_last),           64'h3C);
        checkOutput("t6_rx8_count2", 64'(rx8_cnt - rx8_base), 64'd2);
        checkOutput("t6_ferr8",      64'(frame_err8),         64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
